// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 burst initiator (write/read, len+1 beats)
// Optional 4KB-boundary command rejection: define AXI4_MASTER_4K_CHECK_EN.
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic                    cmd_ready_q;
  logic                    awvalid_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    done_q;
  logic                    err_q;
  logic [1:0]              resp_q;

  logic in_wdata, in_rdata, last_beat, w_hs, r_hs, cross_4k, reject;

  assign in_wdata  = (state_q == S_WDATA);
  assign in_rdata  = (state_q == S_RDATA);
  assign last_beat = (cnt_q == len_q);
  assign w_hs      = in_wdata && wr_valid && WREADY;
  assign r_hs      = in_rdata && RVALID && rd_ready;

`ifdef AXI4_MASTER_4K_CHECK_EN
  if (ADDR_WIDTH > 12) begin : g_4k
    localparam int EW = ADDR_WIDTH + 16;
    logic [EW-1:0] end_addr;
    // Widened so that running past the top of the address space shows up in the upper bits.
    assign end_addr = EW'(cmd_addr) + (EW'({1'b0, cmd_len} + 9'd1) << cmd_size) - EW'(1);
    assign cross_4k = (end_addr[EW-1:ADDR_WIDTH] != '0) ||
                      (end_addr[ADDR_WIDTH-1:12] != cmd_addr[ADDR_WIDTH-1:12]);
  end else begin : g_no_4k
    assign cross_4k = 1'b0;
  end
`else
  assign cross_4k = 1'b0;
`endif

  assign reject = (cmd_size > MAX_SIZE) || cross_4k;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            size_q      <= cmd_size;
            cnt_q       <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            if (reject) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (cmd_write) begin
              awvalid_q <= 1'b1;
              state_q   <= S_WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            state_q   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (last_beat) begin
              bready_q <= 1'b1;
              state_q  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (BVALID) begin
            bready_q <= 1'b0;
            resp_q   <= BRESP;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_RADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (RRESP > resp_q) resp_q <= RRESP;
            if (RLAST != last_beat) err_q <= 1'b1;
            // The beat count, not RLAST, ends the burst.
            if (last_beat) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q & ~ARESET;
  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = size_q;
  assign AWVALID   = awvalid_q;
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = size_q;
  assign ARVALID   = arvalid_q;
  assign BREADY    = bready_q;
  assign WDATA     = in_wdata ? wr_data : '0;
  assign WVALID    = in_wdata & wr_valid;
  assign WLAST     = in_wdata & last_beat;
  assign wr_ready  = in_wdata & WREADY;
  assign rd_data   = in_rdata ? RDATA : '0;
  assign rd_valid  = in_rdata & RVALID;
  assign rd_last   = in_rdata & last_beat;
  assign RREADY    = in_rdata & rd_ready;
  assign done      = done_q;
  assign done_resp = resp_q;
  assign done_err  = err_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - randomized bench for axi4_burst_master with slave/sink model
module tb_axi4_burst_master;
  localparam int DW = 32;
  localparam int AW = 16;

  logic ACLK = 1'b0;
  logic ARESET;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size;
  logic [DW-1:0] wr_data, rd_data;
  logic wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic done, done_err;
  logic [1:0] done_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0] BRESP, RRESP;

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] wdat [256];
  logic [DW-1:0] rdat [256];
  logic [1:0]    rresp_a [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference rule: legal size for a 32-bit bus, optionally no 4KB crossing / address overflow.
  function automatic bit model_reject(input int addr, input int len, input int size);
    bit bad;
    bad = (size > 2);
`ifdef AXI4_MASTER_4K_CHECK_EN
    begin
      int last_byte;
      last_byte = addr + (len + 1) * (1 << size) - 1;
      if (last_byte > 65535 || (last_byte / 4096) != (addr / 4096)) bad = 1'b1;
    end
`endif
    return bad;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = '0; BVALID = 0; ARREADY = 0;
    RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
  endtask

  function automatic logic rnd_ready();
    return ($urandom_range(0, 3) != 0);
  endfunction

  // mode 0: zero-wait slave/source/sink; 1: random stalls; 2: zero-wait except rd_ready toggling
  task automatic run_cmd(input bit wr, input int addr, input int len, input int size,
                         input int mode, input int rlast_beat, input logic [1:0] bresp,
                         input string tag);
    int cyc, w_idx, r_sent, aw_n, ar_n, b_n, done_n, wlast_n, early_n;
    int aw_cyc, w1_cyc, lastw_cyc, bready_cyc, b_cyc, done_cyc;
    bit aw_ok, ar_ok, b_pend, rej, finished, bus;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [1:0] got_resp, exp_resp;
    logic got_err, exp_err;

    w_idx = 0; r_sent = 0; aw_n = 0; ar_n = 0; b_n = 0; done_n = 0; wlast_n = 0; early_n = 0;
    aw_cyc = -1; w1_cyc = -1; lastw_cyc = -1; bready_cyc = -1; b_cyc = -1; done_cyc = -1;
    aw_ok = 0; ar_ok = 0; b_pend = 0; finished = 0;
    got_resp = '0; got_err = 0;

    rej = model_reject(addr, len, size);
    bus = !rej;
    exp_resp = 2'd0;
    if (bus && wr) exp_resp = bresp;
    if (bus && !wr)
      for (int i = 0; i <= len; i++) if (rresp_a[i] > exp_resp) exp_resp = rresp_a[i];
    exp_err = rej || (!wr && rlast_beat != len);

    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = AW'(addr); cmd_len = 8'(len); cmd_size = 3'(size);
    #1 check({tag, ":cmd_ready"}, 64'(cmd_ready), 64'(1));
    @(negedge ACLK);
    cmd_valid = 0;

    cyc = 0;
    while (!finished && cyc < 4000) begin
      cyc++;
      AWREADY  = (mode == 1) ? rnd_ready() : 1'b1;
      WREADY   = (mode == 1) ? rnd_ready() : 1'b1;
      ARREADY  = (mode == 1) ? rnd_ready() : 1'b1;
      wr_valid = (mode == 1) ? rnd_ready() : 1'b1;
      rd_ready = (mode == 1) ? rnd_ready() : (mode == 2) ? 1'(cyc & 1) : 1'b1;
      wr_data  = wdat[w_idx & 255];
      BRESP    = bresp;
      BVALID   = b_pend && ((mode == 1) ? rnd_ready() : 1'b1);
      RVALID   = ar_ok && (r_sent <= len) && ((mode == 1) ? rnd_ready() : 1'b1);
      RDATA    = rdat[r_sent & 255];
      RRESP    = rresp_a[r_sent & 255];
      RLAST    = (r_sent == rlast_beat);
      #1;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BREADY && BVALID;
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      if (AWVALID && aw_cyc < 0) aw_cyc = cyc;
      if (aw_hs) begin
        aw_n++;
        check({tag, ":awaddr"}, 64'(AWADDR), 64'(addr));
        check({tag, ":awlen"},  64'(AWLEN),  64'(len));
        check({tag, ":awsize"}, 64'(AWSIZE), 64'(size));
      end
      if (WVALID && !aw_ok) early_n++;
      if (w_hs) begin
        check({tag, ":wdata"}, 64'(WDATA), 64'(wdat[w_idx & 255]));
        check({tag, ":wlast"}, 64'(WLAST), 64'(w_idx == len));
        if (w1_cyc < 0) w1_cyc = cyc;
        if (WLAST) wlast_n++;
        if (w_idx == len) lastw_cyc = cyc;
      end
      if (BREADY && bready_cyc < 0) bready_cyc = cyc;
      if (b_hs) begin b_n++; b_cyc = cyc; end
      if (ar_hs) begin
        ar_n++;
        check({tag, ":araddr"}, 64'(ARADDR), 64'(addr));
        check({tag, ":arlen"},  64'(ARLEN),  64'(len));
        check({tag, ":arsize"}, 64'(ARSIZE), 64'(size));
      end
      if (r_hs) begin
        check({tag, ":rd_valid"}, 64'(rd_valid), 64'(1));
        check({tag, ":rd_data"},  64'(rd_data),  64'(rdat[r_sent & 255]));
        check({tag, ":rd_last"},  64'(rd_last),  64'(r_sent == len));
      end
      if (done) begin
        done_n++; done_cyc = cyc; got_resp = done_resp; got_err = done_err;
        check({tag, ":cmd_ready_in_done"}, 64'(cmd_ready), 64'(0));
        finished = 1;
      end
      if (aw_hs) aw_ok = 1;
      if (ar_hs) ar_ok = 1;
      if (w_hs) begin
        if (w_idx == len) b_pend = 1;
        w_idx++;
      end
      if (b_hs) b_pend = 0;
      if (r_hs) r_sent++;
      @(negedge ACLK);
    end
    idle_inputs();
    #1;
    if (!finished) check({tag, ":timeout"}, 64'(0), 64'(1));
    check({tag, ":done_pulse_one_cycle"}, 64'(done), 64'(0));
    check({tag, ":done_count"}, 64'(done_n), 64'(1));
    check({tag, ":done_resp"}, 64'(got_resp), 64'(exp_resp));
    check({tag, ":done_err"}, 64'(got_err), 64'(exp_err));
    check({tag, ":aw_count"}, 64'(aw_n), 64'(wr && bus));
    check({tag, ":ar_count"}, 64'(ar_n), 64'(!wr && bus));
    check({tag, ":w_beats"}, 64'(w_idx), 64'((wr && bus) ? len + 1 : 0));
    check({tag, ":r_beats"}, 64'(r_sent), 64'((!wr && bus) ? len + 1 : 0));
    check({tag, ":wlast_count"}, 64'(wlast_n), 64'(wr && bus));
    check({tag, ":b_count"}, 64'(b_n), 64'(wr && bus));
    check({tag, ":w_before_aw"}, 64'(early_n), 64'(0));
    if (rej) check({tag, ":reject_latency"}, 64'(done_cyc), 64'(1));
    if (mode == 0 && wr && bus) begin
      check({tag, ":lat_aw"}, 64'(aw_cyc), 64'(1));
      check({tag, ":lat_w1"}, 64'(w1_cyc), 64'(2));
      check({tag, ":lat_bready"}, 64'(bready_cyc), 64'(lastw_cyc + 1));
      check({tag, ":lat_done"}, 64'(done_cyc), 64'(b_cyc + 1));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      wdat[i]    = $urandom;
      rdat[i]    = $urandom;
      rresp_a[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen, len, rl;
    ARESET = 1'b1;
    idle_inputs();
    fill_random();
    repeat (3) @(negedge ACLK);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_outs", 64'({AWVALID, ARVALID, BREADY, done, done_err, done_resp, WVALID, RREADY, rd_valid}), 64'(0));
    ARESET = 1'b0;
    #1 check("rst_release_cmd_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 256; i++) wdat[i] = 32'hA0 + 32'(i);
    run_cmd(1, 'h0100, 3, 2, 0, 3, 2'd0, "t1_write");

    fill_random();
    for (int i = 0; i < 256; i++) rresp_a[i] = 2'd0;
    rresp_a[5] = 2'd2;
    run_cmd(0, 'h0200, 7, 2, 2, 7, 2'd0, "t2_read_toggle");

    for (int i = 0; i < 256; i++) rresp_a[i] = 2'd0;
    run_cmd(0, 'h0040, 3, 2, 0, 2, 2'd0, "t3_early_rlast");

    run_cmd(1, 'h0080, 0, 3, 0, 0, 2'd0, "t4_bad_size_wr");
    run_cmd(0, 'h0080, 5, 4, 0, 5, 2'd0, "t4_bad_size_rd");

    // Reset in the middle of a write data phase.
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0300; cmd_len = 8'd15; cmd_size = 3'd2;
    AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = 32'h55;
    @(negedge ACLK);
    cmd_valid = 0;
    repeat (3) @(negedge ACLK);
    #1 check("rst_mid_wvalid_before", 64'(WVALID), 64'(1));
    ARESET = 1'b1;
    #1;
    check("rst_mid_outs", 64'({AWVALID, WVALID, wr_ready, WLAST, BREADY, ARVALID, RREADY,
                               rd_valid, rd_last, done, done_err, cmd_ready}), 64'(0));
    check("rst_mid_awaddr", 64'(AWADDR), 64'(0));
    @(negedge ACLK);
    ARESET = 1'b0;
    idle_inputs();
    #1 check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    done_seen = 0;
    repeat (5) begin
      @(negedge ACLK);
      #1 if (done) done_seen++;
    end
    check("rst_mid_no_done", 64'(done_seen), 64'(0));
    run_cmd(1, 'h0310, 0, 2, 0, 0, 2'd1, "t5_after_reset");

    fill_random();
    run_cmd(1, 'h0FF8, 3, 2, 0, 3, 2'd0, "t6_4k_edge");
    run_cmd(1, 'h0000, 255, 0, 0, 255, 2'd3, "t7_len255_wr");
    fill_random();
    run_cmd(0, 'h1000, 255, 0, 1, 255, 2'd0, "t7_len255_rd");

    for (int n = 0; n < 30; n++) begin
      fill_random();
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      rl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : len;
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), len,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rl,
              2'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- AXI4 memory-mapped initiator that drives the slave under test through the same AW/W/B/AR/R signal set. Signal widths and names match the slave's interface (AWADDR, AWLEN, AWSIZE, and so on).
- Accepts one command at a time: a write burst or a read burst.
- Write beats are taken from a data input stream. Read beats are forwarded to a data output stream.
- Used as the active agent in bench and system tests, and as an embedded register/memory initiator.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8..1024, power of two).
- ADDR_WIDTH, 16, address bus width in bits.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  burst start address
- cmd_len  in  8  beats minus 1
- cmd_size  in  3  bytes per beat = 2^cmd_size
- wr_data  in  DATA_WIDTH  write beat data
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed
- rd_data  out  DATA_WIDTH  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  last read beat
- rd_ready  in  1  read sink ready
- done  out  1  one-cycle completion pulse
- done_resp  out  2  worst BRESP/RRESP seen in the burst
- done_err  out  1  protocol or command error
- AWADDR, AWLEN, AWSIZE, AWVALID  out  ADDR_WIDTH/8/3/1  write address channel
- AWREADY  in  1  write address channel
- WDATA, WLAST, WVALID  out  DATA_WIDTH/1/1  write data channel
- WREADY  in  1  write data channel
- BRESP, BVALID  in  2/1  write response channel
- BREADY  out  1  write response channel
- ARADDR, ARLEN, ARSIZE, ARVALID  out  ADDR_WIDTH/8/3/1  read address channel
- ARREADY  in  1  read address channel
- RDATA, RRESP, RLAST, RVALID  in  DATA_WIDTH/2/1/1  read data channel
- RREADY  out  1  read data channel

Behaviour:
- Reset (asynchronous, ARESET=1):
  - State goes to IDLE.
  - All outputs go to 0, except cmd_ready, which is 1 once ARESET deasserts.
  - Any burst in flight is abandoned. No done pulse is produced for it.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch addr, len and size, clear the beat counter, and clear the resp/err accumulators.
  - Command check: if cmd_size > log2(DATA_WIDTH/8), set err=1 and go to DONE with no bus activity.
  - Otherwise go to WADDR if cmd_write, else RADDR.
- WADDR:
  - AWVALID=1 with latched values, held stable until AWREADY.
  - On AWREADY, go to WDATA.
  - W is never asserted before AW is accepted.
- WDATA:
  - Combinational pass-through: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY.
  - WLAST=1 when beat counter == len.
  - Counter increments on each WVALID&&WREADY.
  - The handshake of the last beat moves the FSM to WRESP.
- WRESP:
  - BREADY=1.
  - On BVALID, resp=BRESP, then go to DONE.
- RADDR:
  - ARVALID=1 with latched values, held until ARREADY.
  - Then go to RDATA.
- RDATA:
  - Pass-through: rd_valid=RVALID, rd_data=RDATA, RREADY=rd_ready, rd_last=(counter==len).
  - On each RVALID&&RREADY, resp=max(resp,RRESP).
  - If RLAST != (counter==len), set err=1.
  - Counter increments on each beat.
  - The beat with counter==len moves the FSM to DONE, regardless of RLAST.
- DONE:
  - done=1 for exactly one cycle, with done_resp and done_err valid in that cycle.
  - Then go to IDLE.
  - cmd_ready=0 in every state except IDLE. This gives one outstanding burst and a minimum of 1 idle cycle between commands.
- Latency, zero-wait slave, write burst:
  - Command handshake in cycle 0.
  - AWVALID in cycle 1.
  - First W beat in cycle 2.
  - BREADY in the cycle after the last W beat.
  - done in the cycle after the B handshake.
- Beat counter: 8 bits; len=255 gives 256 beats with no wrap before the last beat.
- Address is not incremented by the master. INCR bursting is implied and address generation is left to the slave.
- Outputs: AW/AR/BREADY and state-derived outputs are registered. Data-path pass-throughs are combinational.

Optional Feature:
- Macro: AXI4_MASTER_4K_CHECK_EN.
- Defined:
  - In IDLE, compute the end address as cmd_addr + (cmd_len+1)*2^cmd_size - 1.
  - If bits [ADDR_WIDTH-1:12] of start and end differ, or the end address overflows ADDR_WIDTH, the command is rejected.
  - A rejected command gives err=1 and goes straight to DONE with no AW/AR issued.
  - The check applies only when ADDR_WIDTH > 12.
- Undefined: no boundary check; the burst is issued as given.

Test Plan:
- Write with addr=0x0100, len=3, size=2, wr_data 0xA0..0xA3, zero-wait slave, BRESP=0 -> exactly 4 W beats, WLAST on the 4th only, done one cycle after B, done_resp=0, done_err=0.
- Read with addr=0x0200, len=7, size=2, slave RRESP=0 except beat 5 =2 (SLVERR), rd_ready toggling 1/0 -> 8 rd beats in order, rd_last on the 8th, done_resp=2, done_err=0.
- Read with len=3 where the slave asserts RLAST on beat 2 -> done after the 4th beat with done_err=1.
- Command with size=3 and DATA_WIDTH=32 -> no AWVALID/ARVALID, done next cycle, done_err=1.
- ARESET pulsed during WDATA of a len=15 write -> all channel outputs 0 immediately, no done, cmd_ready=1 after release; a following len=0 write completes normally.
- With AXI4_MASTER_4K_CHECK_EN defined and ADDR_WIDTH=16: addr=0x0FF8, len=3, size=2 -> rejected, done_err=1, no AW. Same command with the macro undefined -> AW issued.
